// File: rtl/fifo_uart_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fifo_uart_tx_if                                                  |
// | Purpose  : Read-side bundle between a FIFO and its UART transmitter         |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface fifo_uart_tx_if #(
   parameter int DATA_W = 8
);
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_data;
   logic              fifo_r_en;

   // master = the transmitter pulling bytes, slave = the FIFO supplying them
   modport master (
      input  fifo_empty,
      input  fifo_data,
      output fifo_r_en
   );

   modport slave (
      output fifo_empty,
      output fifo_data,
      input  fifo_r_en
   );
endinterface

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fifo_uart_tx                                                     |
// | Purpose  : Drains a FIFO byte by byte and serialises each as a UART frame   |
// |            (start, data LSB first, optional even parity, stop).             |
// | Options  : define FIFO_UART_TX_PARITY_EN to insert the parity bit           |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_W       = 8
) (
   input  wire            clk,
   input  wire            rst,
   input  wire            tx_en,
   fifo_uart_tx_if.master fifo,
   output logic           tx,
   output logic           busy,
   output logic           frame_done
);

   localparam int c_baud_w = $clog2(CLKS_PER_BIT);
   localparam int c_bit_w  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
   localparam logic [c_baud_w-1:0] c_baud_pre  = c_baud_w'(CLKS_PER_BIT - 2);
   localparam logic [c_baud_w-1:0] c_baud_one  = c_baud_w'(1);
   localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(DATA_W - 1);
   localparam logic [c_bit_w-1:0]  c_bit_one   = c_bit_w'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_START  = 3'd2,
      S_DATA   = 3'd3,
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY = 3'd5,
`endif
      S_STOP   = 3'd4
   } state_t;

   state_t              r_state;
   logic [c_baud_w-1:0] r_baud;
   logic [c_bit_w-1:0]  r_bit_idx;
   logic [DATA_W-1:0]   r_shift;
`ifdef FIFO_UART_TX_PARITY_EN
   logic                r_parity;
`endif

   logic                w_bit_end;
   logic [DATA_W-1:0]   w_shift_next;

   assign w_bit_end    = (r_baud == c_baud_last);
   assign w_shift_next = r_shift >> 1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= S_IDLE;
         r_baud         <= '0;
         r_bit_idx      <= '0;
         r_shift        <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
         r_parity       <= 1'b0;
`endif
         tx             <= 1'b1;
         busy           <= 1'b0;
         frame_done     <= 1'b0;
         fifo.fifo_r_en <= 1'b0;
      end else begin
         fifo.fifo_r_en <= 1'b0;
         frame_done     <= 1'b0;

         case (r_state)
            S_IDLE: begin
               tx     <= 1'b1;
               busy   <= 1'b0;
               r_baud <= '0;
               if (tx_en && !fifo.fifo_empty) begin
                  fifo.fifo_r_en <= 1'b1;
                  busy           <= 1'b1;
                  r_state        <= S_FETCH;
               end
            end

            // The strobe is being seen by the FIFO now; its head byte is on fifo_data.
            S_FETCH: begin
               r_shift   <= fifo.fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
               r_parity  <= ^fifo.fifo_data;
`endif
               r_baud    <= '0;
               r_bit_idx <= '0;
               tx        <= 1'b0;
               r_state   <= S_START;
            end

            S_START: begin
               if (w_bit_end) begin
                  r_baud  <= '0;
                  tx      <= r_shift[0];
                  r_state <= S_DATA;
               end else begin
                  r_baud <= r_baud + c_baud_one;
               end
            end

            S_DATA: begin
               if (w_bit_end) begin
                  r_baud  <= '0;
                  r_shift <= w_shift_next;
                  if (r_bit_idx == c_bit_last) begin
`ifdef FIFO_UART_TX_PARITY_EN
                     tx      <= r_parity;
                     r_state <= S_PARITY;
`else
                     tx      <= 1'b1;
                     r_state <= S_STOP;
`endif
                  end else begin
                     r_bit_idx <= r_bit_idx + c_bit_one;
                     tx        <= w_shift_next[0];
                  end
               end else begin
                  r_baud <= r_baud + c_baud_one;
               end
            end

`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
               if (w_bit_end) begin
                  r_baud  <= '0;
                  tx      <= 1'b1;
                  r_state <= S_STOP;
               end else begin
                  r_baud <= r_baud + c_baud_one;
               end
            end
`endif

            // frame_done is raised one count early so it lands in the final stop cycle.
            S_STOP: begin
               frame_done <= (r_baud == c_baud_pre);
               if (w_bit_end) begin
                  r_baud  <= '0;
                  tx      <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_baud <= r_baud + c_baud_one;
               end
            end

            default: begin
               tx      <= 1'b1;
               busy    <= 1'b0;
               r_baud  <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fifo_uart_tx                                                  |
// | Purpose  : Directed + random frames against a bit-level UART frame model    |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fifo_uart_tx;

   localparam int CLKS = 4;
   localparam int W    = 8;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int NBITS = W + 3;
`else
   localparam int NBITS = W + 2;
`endif
   localparam int FRAME = NBITS * CLKS;

   logic clk = 1'b0;
   logic rst;
   logic tx_en;
   logic tx;
   logic busy;
   logic frame_done;

   fifo_uart_tx_if #(.DATA_W(W)) fif ();

   // FIFO model: first-word-fall-through, popped just after the edge that sees the strobe
   logic [W-1:0] mem [0:255];
   int wr_cnt = 0;
   int rd_cnt = 0;
   int rd_pulses = 0;
   int rd_while_empty = 0;
   int n_checks = 0;
   int n_pass = 0;

   assign fif.fifo_empty = (wr_cnt == rd_cnt);
   assign fif.fifo_data  = mem[rd_cnt[7:0]];

   always #5 clk = ~clk;

   fifo_uart_tx #(
      .CLKS_PER_BIT(CLKS),
      .DATA_W      (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tx_en     (tx_en),
      .fifo      (fif),
      .tx        (tx),
      .busy      (busy),
      .frame_done(frame_done)
   );

   always begin
      @(negedge clk);
      if (fif.fifo_r_en === 1'b1) begin
         rd_pulses++;
         if (fif.fifo_empty) rd_while_empty++;
         @(posedge clk);
         #1;
         rd_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic push(input logic [W-1:0] b);
      mem[wr_cnt[7:0]] = b;
      wr_cnt++;
   endtask

   // Line level of serial bit slot idx for byte b
   function automatic logic exp_bit(input logic [W-1:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= W) return b[idx-1];
`ifdef FIFO_UART_TX_PARITY_EN
      if (idx == W + 1) return ^b;
`endif
      return 1'b1;
   endfunction

   // Waits for the start bit, checks every cycle of the frame and the idle cycle after it.
   // pre returns the number of tx-high cycles seen before the start bit.
   task automatic check_frame(input logic [W-1:0] b, input int drop_at, output int pre);
      logic         found;
      logic [W-1:0] rx;
      found = 1'b0;
      rx    = '0;
      pre   = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (tx === 1'b0) begin
            found = 1'b1;
            break;
         end
         pre++;
      end
      chk("frame_start", {31'd0, found}, 32'd1);
      if (!found) return;
      for (int k = 0; k < FRAME; k++) begin
         if (k > 0) @(negedge clk);
         if (k == drop_at) tx_en = 1'b0;
         chk($sformatf("tx_slot%0d_cyc%0d", k / CLKS, k), {31'd0, tx}, {31'd0, exp_bit(b, k / CLKS)});
         chk("busy_in_frame", {31'd0, busy}, 32'd1);
         chk("frame_done", {31'd0, frame_done}, {31'd0, (k == FRAME - 1)});
         if ((k % CLKS) == CLKS / 2 && (k / CLKS) >= 1 && (k / CLKS) <= W)
            rx[(k / CLKS) - 1] = tx;
      end
      chk("decoded_byte", {24'd0, rx}, {24'd0, b});
      @(negedge clk);
      chk("busy_after", {31'd0, busy}, 32'd0);
      chk("tx_after", {31'd0, tx}, 32'd1);
      chk("done_after", {31'd0, frame_done}, 32'd0);
   endtask

   initial begin
      int           pre;
      int           exp_reads;
      logic         found;
      logic [W-1:0] rb [8];

      // Reset hold with data available and tx_en high
      rst   = 1'b0;
      tx_en = 1'b1;
      push(8'hA1);
      repeat (3) begin
         @(negedge clk);
         chk("rst_tx", {31'd0, tx}, 32'd1);
         chk("rst_rd", {31'd0, fif.fifo_r_en}, 32'd0);
         chk("rst_busy", {31'd0, busy}, 32'd0);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("rd_first_edge", {31'd0, fif.fifo_r_en}, 32'd1);
      chk("busy_fetch", {31'd0, busy}, 32'd1);

      // Single byte 0xA1
      check_frame(8'hA1, -1, pre);
      chk("a1_pre", pre, 32'd0);
      exp_reads = 1;
      chk("a1_reads", rd_pulses, exp_reads);
      chk("a1_empty", {31'd0, fif.fifo_empty}, 32'd1);

      // Back-to-back 0xB2, 0xC3
      push(8'hB2);
      push(8'hC3);
      check_frame(8'hB2, -1, pre);
      check_frame(8'hC3, -1, pre);
      chk("b2b_gap", pre + 1, 32'd2);
      exp_reads += 2;
      chk("b2b_reads", rd_pulses, exp_reads);
      chk("b2b_empty", {31'd0, fif.fifo_empty}, 32'd1);

      // Empty FIFO hold-off
      repeat (50) begin
         @(negedge clk);
         chk("empty_tx", {31'd0, tx}, 32'd1);
         chk("empty_rd", {31'd0, fif.fifo_r_en}, 32'd0);
      end

      // tx_en low with data waiting
      tx_en = 1'b0;
      push(8'h55);
      repeat (20) begin
         @(negedge clk);
         chk("hold_tx", {31'd0, tx}, 32'd1);
         chk("hold_rd", {31'd0, fif.fifo_r_en}, 32'd0);
         chk("hold_busy", {31'd0, busy}, 32'd0);
      end

      // tx_en dropped mid-frame: frame completes, no further read
      push(8'h99);
      tx_en = 1'b1;
      check_frame(8'h55, 10, pre);
      repeat (20) begin
         @(negedge clk);
         chk("drop_rd", {31'd0, fif.fifo_r_en}, 32'd0);
         chk("drop_tx", {31'd0, tx}, 32'd1);
      end
      exp_reads += 1;
      chk("drop_reads", rd_pulses, exp_reads);
      chk("drop_not_empty", {31'd0, fif.fifo_empty}, 32'd0);
      tx_en = 1'b1;
      check_frame(8'h99, -1, pre);
      exp_reads += 1;

      // Reset during data bit 3 of 0x0F; 0x0F is lost, 0x11 follows cleanly
      push(8'h0F);
      push(8'h11);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (tx === 1'b0) begin
            found = 1'b1;
            break;
         end
      end
      chk("mid_start", {31'd0, found}, 32'd1);
      repeat (4 * CLKS + 1) @(negedge clk);
      chk("mid_busy_pre", {31'd0, busy}, 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_tx", {31'd0, tx}, 32'd1);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_rd", {31'd0, fif.fifo_r_en}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      check_frame(8'h11, -1, pre);
      exp_reads += 2;
      chk("mid_reads", rd_pulses, exp_reads);
      chk("mid_empty", {31'd0, fif.fifo_empty}, 32'd1);

      // Random back-to-back bytes
      for (int n = 0; n < 8; n++) begin
         rb[n] = W'($urandom_range(0, 255));
         push(rb[n]);
      end
      for (int n = 0; n < 8; n++) begin
         check_frame(rb[n], -1, pre);
         chk($sformatf("rand_gap%0d", n), pre + 1, 32'd2);
      end
      exp_reads += 8;
      chk("rand_reads", rd_pulses, exp_reads);
      chk("rand_empty", {31'd0, fif.fifo_empty}, 32'd1);

`ifdef FIFO_UART_TX_PARITY_EN
      push(8'h07);
      push(8'h03);
      check_frame(8'h07, -1, pre);
      check_frame(8'h03, -1, pre);
      exp_reads += 2;
      chk("par_reads", rd_pulses, exp_reads);
`endif

      chk("rd_while_empty", rd_while_empty, 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
